// File: rtl/imm_packer.sv
// imm_packer: inserts a 32-bit immediate into the I/S/B/J fields of a base
// instruction word, flags range/alignment violations, 2-stage valid/ready pipe.
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   input handshake for {base_instr, imm, ImmScr}
//   base_instr          non-immediate bits of the instruction
//   imm                 signed immediate (byte offset for B/J)
//   ImmScr              00=I 01=S 10=B 11=J
//   out_valid/out_ready output handshake for {out_instr, out_err}
//   out_instr, out_err  packed word and its violation flag
//   cnt_ok, cnt_err     saturating counts of good / rejected words
module imm_packer #(
    parameter int CNT_W  = 16,
    parameter bit STRICT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      base_instr,
    input  logic [31:0]      imm,
    input  logic [1:0]       ImmScr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_err
);

    logic        s1_valid;
    logic [31:0] s1_base;
    logic [20:0] s1_imm;
    logic [1:0]  s1_scr;
    logic        s1_err;

    logic        chk_err;
    logic [31:0] packed_w;
    logic        s2_free;
    logic        s1_adv;
    logic        in_fire;
    logic        s2_take;

    // Range/alignment check on the raw input; only the low 21 imm bits
    // are needed past this point.
    always_comb begin
        chk_err = 1'b0;
        unique case (ImmScr)
            2'b00, 2'b01: chk_err = !((&imm[31:11]) || !(|imm[31:11]));
            2'b10:        chk_err = !((&imm[31:12]) || !(|imm[31:12]))
                                    || imm[0];
            2'b11:        chk_err = !((&imm[31:20]) || !(|imm[31:20]))
                                    || imm[0];
        endcase
    end

    always_comb begin
        packed_w = s1_base;
        unique case (s1_scr)
            2'b00: packed_w = {s1_imm[11:0], s1_base[19:0]};
            2'b01: packed_w = {s1_imm[11:5], s1_base[24:12],
                               s1_imm[4:0], s1_base[6:0]};
            2'b10: packed_w = {s1_imm[12], s1_imm[10:5], s1_base[24:12],
                               s1_imm[4:1], s1_imm[11], s1_base[6:0]};
            2'b11: packed_w = {s1_imm[20], s1_imm[10:1], s1_imm[11],
                               s1_imm[19:12], s1_base[11:0]};
        endcase
    end

    assign s2_free  = !out_valid || out_ready;
    assign s1_adv   = s1_valid && s2_free;
    assign in_ready = !s1_valid || s1_adv;
    assign in_fire  = in_valid && in_ready;
    // In strict mode a rejected word is consumed here and never shown.
    assign s2_take  = s1_adv && !(STRICT && s1_err);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_base  <= '0;
            s1_imm   <= '0;
            s1_scr   <= '0;
            s1_err   <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_base  <= base_instr;
                s1_imm   <= imm[20:0];
                s1_scr   <= ImmScr;
                s1_err   <= chk_err;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
        end else if (s2_free) begin
            out_valid <= s2_take;
            if (s2_take) begin
                out_instr <= packed_w;
                out_err   <= s1_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_ok  <= '0;
            cnt_err <= '0;
        end else if (s1_adv) begin
            if (s1_err) begin
                if (cnt_err != '1) cnt_err <= cnt_err + 1'b1;
            end else begin
                if (cnt_ok != '1) cnt_ok <= cnt_ok + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imm_packer.sv
// tb_imm_packer: directed checks of imm_packer packing, checks, handshake,
// reset and counter saturation (default, STRICT=1 and CNT_W=2 instances).
module tb_imm_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] base_instr = '0;
    logic [31:0] imm = '0;
    logic [1:0]  ImmScr = '0;
    logic        out_ready = 1'b1;

    logic        in_ready, out_valid, out_err;
    logic [31:0] out_instr;
    logic [15:0] cnt_ok, cnt_err;

    logic        s_in_ready, s_out_valid, s_out_err;
    logic [31:0] s_out_instr;
    logic [15:0] s_cnt_ok, s_cnt_err;

    logic        t_in_ready, t_out_valid, t_out_err;
    logic [31:0] t_out_instr;
    logic [1:0]  t_cnt_ok, t_cnt_err;

    int tests = 0;
    int fails = 0;
    logic [32:0] got_q[$];
    int s_seen = 0;

    always #5 clk = ~clk;

    imm_packer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .base_instr(base_instr), .imm(imm), .ImmScr(ImmScr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_err(out_err),
        .cnt_ok(cnt_ok), .cnt_err(cnt_err)
    );

    imm_packer #(.CNT_W(16), .STRICT(1'b1)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
        .base_instr(base_instr), .imm(imm), .ImmScr(ImmScr),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_instr(s_out_instr), .out_err(s_out_err),
        .cnt_ok(s_cnt_ok), .cnt_err(s_cnt_err)
    );

    imm_packer #(.CNT_W(2), .STRICT(1'b0)) dut_t (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(t_in_ready),
        .base_instr(base_instr), .imm(imm), .ImmScr(ImmScr),
        .out_valid(t_out_valid), .out_ready(out_ready),
        .out_instr(t_out_instr), .out_err(t_out_err),
        .cnt_ok(t_cnt_ok), .cnt_err(t_cnt_err)
    );

    // Inputs change at posedge+1, so negedge sees settled handshakes.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready)
            got_q.push_back({out_err, out_instr});
        if (!reset && s_out_valid && out_ready)
            s_seen++;
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        got_q.delete();
        s_seen = 0;
    endtask

    task automatic push(input logic [31:0] b, input logic [31:0] i,
                        input logic [1:0] s);
        logic w;
        int n;
        in_valid = 1'b1;
        base_instr = b;
        imm = i;
        ImmScr = s;
        n = 0;
        do begin
            @(negedge clk);
            w = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!w && n < 40);
        if (!w) begin
            tests++; fails++;
            $display("FAIL push_timeout: in_ready stuck at 0, required 1");
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic wait_q(input int n);
        int k;
        k = 0;
        while (got_q.size() < n && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        tests++;
        if (got_q.size() < n) begin
            fails++;
            $display("FAIL wait_out: got %0d words, required %0d",
                     got_q.size(), n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_out_valid: got %b, required 0", out_valid);
        end
        tests++;
        if (out_instr !== 32'h0 || out_err !== 1'b0) begin
            fails++;
            $display("FAIL rst_out_data: got %h/%b, required 0/0",
                     out_instr, out_err);
        end
        tests++;
        if (cnt_ok !== 16'd0 || cnt_err !== 16'd0) begin
            fails++;
            $display("FAIL rst_cnt: got %0d/%0d, required 0/0",
                     cnt_ok, cnt_err);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_in_ready: got %b, required 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_i_latency();
        do_reset();
        out_ready = 1'b1;
        push(32'h00000093, 32'hFFFFFFFF, 2'b00);
        idle();
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL i_lat1: out_valid got %b, required 0", out_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || out_instr !== 32'hFFF00093
            || out_err !== 1'b0) begin
            fails++;
            $display("FAIL i_pack: got v=%b %h e=%b, required v=1 fff00093 e=0",
                     out_valid, out_instr, out_err);
        end
        tests++;
        if (cnt_ok !== 16'd1) begin
            fails++;
            $display("FAIL i_cnt_ok: got %0d, required 1", cnt_ok);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sbj();
        logic [31:0] exp [3];
        exp[0] = 32'h00002423;
        exp[1] = 32'hFE000EE3;
        exp[2] = 32'h0010006F;
        do_reset();
        out_ready = 1'b1;
        push(32'h00002023, 32'h00000008, 2'b01);
        push(32'h00000063, 32'hFFFFFFFC, 2'b10);
        push(32'h0000006F, 32'h00000800, 2'b11);
        idle();
        wait_q(3);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (got_q.size() <= k || got_q[k] !== {1'b0, exp[k]}) begin
                fails++;
                $display("FAIL sbj_word%0d: got %h, required 0_%h", k,
                         (got_q.size() > k) ? got_q[k] : 33'h0, exp[k]);
            end
        end
        tests++;
        if (cnt_ok !== 16'd3 || cnt_err !== 16'd0) begin
            fails++;
            $display("FAIL sbj_cnt: got %0d/%0d, required 3/0",
                     cnt_ok, cnt_err);
        end
    endtask

    task automatic test_errors();
        do_reset();
        out_ready = 1'b1;
        push(32'h00000093, 32'h00000800, 2'b00);
        push(32'h00000063, 32'h00000003, 2'b10);
        push(32'h00000093, 32'h00000005, 2'b00);
        idle();
        wait_q(3);
        repeat (3) begin
            @(posedge clk); #1;
        end
        tests++;
        if (got_q.size() < 3 || got_q[0] !== {1'b1, 32'h80000093}) begin
            fails++;
            $display("FAIL err_i: got %h, required 1_80000093",
                     (got_q.size() > 0) ? got_q[0] : 33'h0);
        end
        tests++;
        if (got_q.size() < 3 || got_q[1] !== {1'b1, 32'h00000163}) begin
            fails++;
            $display("FAIL err_b: got %h, required 1_00000163",
                     (got_q.size() > 1) ? got_q[1] : 33'h0);
        end
        tests++;
        if (got_q.size() < 3 || got_q[2] !== {1'b0, 32'h00500093}) begin
            fails++;
            $display("FAIL err_good: got %h, required 0_00500093",
                     (got_q.size() > 2) ? got_q[2] : 33'h0);
        end
        tests++;
        if (cnt_err !== 16'd2 || cnt_ok !== 16'd1) begin
            fails++;
            $display("FAIL err_cnt: got ok=%0d err=%0d, required 1/2",
                     cnt_ok, cnt_err);
        end
        tests++;
        if (s_seen !== 1) begin
            fails++;
            $display("FAIL strict_outs: got %0d words, required 1", s_seen);
        end
        tests++;
        if (s_cnt_err !== 16'd2 || s_cnt_ok !== 16'd1) begin
            fails++;
            $display("FAIL strict_cnt: got ok=%0d err=%0d, required 1/2",
                     s_cnt_ok, s_cnt_err);
        end
        tests++;
        if (s_out_instr !== 32'h00500093 || s_out_err !== 1'b0) begin
            fails++;
            $display("FAIL strict_last: got %h/%b, required 00500093/0",
                     s_out_instr, s_out_err);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp [3];
        logic [31:0] hold;
        exp[0] = 32'h00A00093;
        exp[1] = 32'h00B00093;
        exp[2] = 32'h00C00093;
        do_reset();
        out_ready = 1'b0;
        push(32'h00000093, 32'h0000000A, 2'b00);
        push(32'h00000093, 32'h0000000B, 2'b00);
        in_valid = 1'b1;
        base_instr = 32'h00000093;
        imm = 32'h0000000C;
        ImmScr = 2'b00;
        @(negedge clk);
        hold = out_instr;
        for (int c = 0; c < 5; c++) begin
            tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1
                || out_instr !== exp[0] || out_instr !== hold) begin
                fails++;
                $display("FAIL bp_hold%0d: rdy=%b v=%b %h, required 0 1 %h",
                         c, in_ready, out_valid, out_instr, exp[0]);
            end
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: in_ready got %b, required 1", in_ready);
        end
        @(posedge clk); #1;
        idle();
        wait_q(3);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (got_q.size() <= k || got_q[k] !== {1'b0, exp[k]}) begin
                fails++;
                $display("FAIL bp_order%0d: got %h, required 0_%h", k,
                         (got_q.size() > k) ? got_q[k] : 33'h0, exp[k]);
            end
        end
        tests++;
        if (got_q.size() !== 3) begin
            fails++;
            $display("FAIL bp_count: got %0d words, required 3", got_q.size());
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        out_ready = 1'b0;
        push(32'h00000093, 32'h00000001, 2'b00);
        push(32'h00000093, 32'h00000002, 2'b00);
        idle();
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || cnt_ok !== 16'd1) begin
            fails++;
            $display("FAIL mid_full: v=%b rdy=%b ok=%0d, required 1 0 1",
                     out_valid, in_ready, cnt_ok);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1
            || cnt_ok !== 16'd0 || cnt_err !== 16'd0) begin
            fails++;
            $display("FAIL mid_reset: v=%b rdy=%b ok=%0d err=%0d, required 0 1 0 0",
                     out_valid, in_ready, cnt_ok, cnt_err);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        tests++;
        if (got_q.size() !== 0 || cnt_ok !== 16'd0) begin
            fails++;
            $display("FAIL mid_after: got %0d words ok=%0d, required 0 0",
                     got_q.size(), cnt_ok);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++)
            push(32'h00000013, k, 2'b00);
        idle();
        repeat (4) begin
            @(posedge clk); #1;
        end
        tests++;
        if (t_cnt_ok !== 2'd3 || t_cnt_err !== 2'd0) begin
            fails++;
            $display("FAIL sat_cnt: got ok=%0d err=%0d, required 3/0",
                     t_cnt_ok, t_cnt_err);
        end
        tests++;
        if (cnt_ok !== 16'd5) begin
            fails++;
            $display("FAIL sat_wide: got %0d, required 5", cnt_ok);
        end
    endtask

    initial begin
        test_reset();
        test_i_latency();
        test_sbj();
        test_errors();
        test_backpressure();
        test_reset_midop();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
